// File: rtl/gravsim_regfile.sv
// Multi-ported simulation register file: globals, START/DONE handshake and per-planet fields,
// shared between the physics engine lane groups, a host Avalon-MM port and an ACC clear sweep.
module gravsim_regfile #(
  parameter int MAX_PLANETS = 10,
  parameter int GROUP_SIZE  = 3,
  parameter int NUM_GROUPS  = 2,
  parameter int ADDR_W      = 8
) (
  input  logic                                     CLK,
  input  logic                                     RESET_N,
  input  logic                                     AVL_CS,
  input  logic                                     AVL_READ,
  input  logic                                     AVL_WRITE,
  input  logic [ADDR_W-1:0]                        AVL_ADDR,
  input  logic [31:0]                              AVL_WRITEDATA,
  output logic [31:0]                              AVL_READDATA,
  input  logic [NUM_GROUPS-1:0]                    FSM_RE,
  input  logic [NUM_GROUPS-1:0]                    FSM_WE,
  input  logic [GROUP_SIZE*NUM_GROUPS*ADDR_W-1:0]  ADDR,
  input  logic [GROUP_SIZE*NUM_GROUPS*32-1:0]      WDATA,
  output logic [GROUP_SIZE*NUM_GROUPS*32-1:0]      RDATA,
  input  logic                                     CLEAR_ACCS,
  output logic                                     CLEAR_BUSY,
  input  logic                                     FSM_DONE,
  output logic                                     FSM_START,
  output logic [31:0]                              G,
  output logic [3:0]                               PLANET_NUM
);
  localparam int LANES = GROUP_SIZE * NUM_GROUPS;
  localparam int DEPTH = 4 + 11 * MAX_PLANETS;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = (MAX_PLANETS > 1) ? $clog2(MAX_PLANETS) : 1;
  localparam logic [AW-1:0] ACC_X = AW'(4 + 8 * MAX_PLANETS);
  localparam logic [AW-1:0] ACC_Y = AW'(4 + 9 * MAX_PLANETS);
  localparam logic [AW-1:0] ACC_Z = AW'(4 + 10 * MAX_PLANETS);
  localparam logic [PW-1:0] P_LAST  = PW'(MAX_PLANETS - 1);
  localparam logic [31:0]   NUM_MAX = 32'(MAX_PLANETS);

  typedef enum logic {IDLE, SWEEP} sweep_t;

  logic [31:0] mem [DEPTH];
  sweep_t      state, state_n;
  logic [PW-1:0] p, p_n;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W+1)'(DEPTH);
  endfunction

  function automatic logic [AW-1:0] idx(input logic [ADDR_W-1:0] a);
    return a[AW-1:0];
  endfunction

  function automatic logic [31:0] rd_word(input logic [ADDR_W-1:0] a);
    return in_range(a) ? mem[idx(a)] : '0;
  endfunction

  assign G          = mem[0];
  assign PLANET_NUM = mem[1][3:0];
  assign FSM_START  = mem[2][0];
  assign CLEAR_BUSY = (state == SWEEP);

  // Host writes are locked out while a run is active, except START itself.
  logic        host_ok;
  logic [31:0] host_val;
  assign host_ok  = AVL_CS && AVL_WRITE && in_range(AVL_ADDR) &&
                    (!mem[2][0] || AVL_ADDR == ADDR_W'(2));
  assign host_val = (AVL_ADDR == ADDR_W'(1) && AVL_WRITEDATA > NUM_MAX) ? NUM_MAX : AVL_WRITEDATA;

  logic [LANES-1:0][ADDR_W-1:0] lane_addr;
  logic [LANES-1:0][31:0]       lane_wd;
  logic [LANES-1:0]             lane_we;
  assign lane_addr = ADDR;
  assign lane_wd   = WDATA;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int GRP = k / GROUP_SIZE;
    logic [31:0] rdata_q;
    assign lane_we[k]          = FSM_WE[GRP] && in_range(lane_addr[k]);
    assign RDATA[k*32 +: 32]   = rdata_q;
    always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N)        rdata_q <= '0;
      else if (FSM_RE[GRP]) rdata_q <= rd_word(lane_addr[k]);
  end

  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N)                AVL_READDATA <= '0;
    else if (AVL_CS && AVL_READ) AVL_READDATA <= rd_word(AVL_ADDR);

  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state <= IDLE;
      p     <= '0;
    end else begin
      state <= state_n;
      p     <= p_n;
    end

  always_comb begin
    state_n = state;
    p_n     = p;
    case (state)
      IDLE:  if (CLEAR_ACCS) begin
               state_n = SWEEP;
               p_n     = '0;
             end
      SWEEP: if (p == P_LAST) begin
               state_n = IDLE;
               p_n     = '0;
             end else begin
               p_n = p + PW'(1);
             end
      default: state_n = IDLE;
    endcase
  end

  // Writers are issued lowest priority first so later non-blocking writes win.
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (host_ok) begin
        mem[idx(AVL_ADDR)] <= host_val;
        if (AVL_ADDR == ADDR_W'(2) && AVL_WRITEDATA[0]) mem[3] <= '0;
      end
      if (state == SWEEP) begin
        mem[ACC_X + AW'(p)] <= '0;
        mem[ACC_Y + AW'(p)] <= '0;
        mem[ACC_Z + AW'(p)] <= '0;
      end
      for (int k = 0; k < LANES; k++)
        if (lane_we[k]) mem[idx(lane_addr[k])] <= lane_wd[k];
      if (FSM_DONE) begin
        mem[2] <= '0;
        mem[3] <= 32'd1;
      end
    end
endmodule

// File: tb/tb_gravsim_regfile.sv
// Directed + randomized bench for gravsim_regfile against a word-array reference model.
module tb_gravsim_regfile;
  localparam int MP = 10, GS = 3, NG = 2, AW = 8;
  localparam int LANES = GS * NG;
  localparam int DEPTH = 4 + 11 * MP;

  logic CLK = 1'b0;
  logic RESET_N;
  logic avl_cs, avl_read, avl_write;
  logic [AW-1:0] avl_addr;
  logic [31:0] avl_wd, avl_rdata;
  logic [NG-1:0] fsm_re, fsm_we;
  logic [LANES-1:0][AW-1:0] laddr;
  logic [LANES-1:0][31:0]   lwd;
  logic [LANES*32-1:0] rdata;
  logic clear_accs, clear_busy, fsm_done, fsm_start;
  logic [31:0] g_out;
  logic [3:0] pnum;

  gravsim_regfile #(.MAX_PLANETS(MP), .GROUP_SIZE(GS), .NUM_GROUPS(NG), .ADDR_W(AW)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .AVL_CS(avl_cs), .AVL_READ(avl_read), .AVL_WRITE(avl_write),
    .AVL_ADDR(avl_addr), .AVL_WRITEDATA(avl_wd), .AVL_READDATA(avl_rdata),
    .FSM_RE(fsm_re), .FSM_WE(fsm_we), .ADDR(laddr), .WDATA(lwd), .RDATA(rdata),
    .CLEAR_ACCS(clear_accs), .CLEAR_BUSY(clear_busy), .FSM_DONE(fsm_done),
    .FSM_START(fsm_start), .G(g_out), .PLANET_NUM(pnum)
  );

  always #5 CLK = ~CLK;

  int vecs = 0, errs = 0;
  logic [31:0] m [DEPTH];
  logic [31:0] e_avl;
  logic [31:0] e_rd [LANES];
  int sw_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m[i] = '0;
    for (int k = 0; k < LANES; k++) e_rd[k] = '0;
    e_avl = '0;
    sw_left = 0;
  endtask

  // Applies the currently driven inputs to the model: one clock edge worth of effects.
  task automatic model_step();
    logic [31:0] nm [DEPTH];
    int a;
    nm = m;
    a = int'(avl_addr);
    if (avl_cs && avl_write && a < DEPTH && (m[2][0] == 1'b0 || a == 2)) begin
      nm[a] = (a == 1 && avl_wd > 32'(MP)) ? 32'(MP) : avl_wd;
      if (a == 2 && avl_wd[0]) nm[3] = '0;
    end
    if (sw_left > 0)
      for (int f = 8; f <= 10; f++) nm[4 + f*MP + (MP - sw_left)] = '0;
    for (int k = 0; k < LANES; k++)
      if (fsm_we[k/GS] && int'(laddr[k]) < DEPTH) nm[laddr[k]] = lwd[k];
    if (fsm_done) begin
      nm[2] = '0;
      nm[3] = 32'd1;
    end
    if (avl_cs && avl_read) e_avl = (a < DEPTH) ? m[a] : '0;
    for (int k = 0; k < LANES; k++)
      if (fsm_re[k/GS]) e_rd[k] = (int'(laddr[k]) < DEPTH) ? m[laddr[k]] : '0;
    if (sw_left > 0) sw_left--;
    else if (clear_accs) sw_left = MP;
    m = nm;
  endtask

  task automatic check_all();
    chk("busy", {31'b0, clear_busy}, {31'b0, sw_left > 0});
    chk("start", {31'b0, fsm_start}, {31'b0, m[2][0]});
    chk("g", g_out, m[0]);
    chk("pnum", {28'b0, pnum}, {28'b0, m[1][3:0]});
    chk("avl_rd", avl_rdata, e_avl);
    for (int k = 0; k < LANES; k++) chk($sformatf("rdata%0d", k), rdata[k*32 +: 32], e_rd[k]);
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    check_all();
  endtask

  task automatic idle();
    avl_cs = 0; avl_read = 0; avl_write = 0; avl_addr = '0; avl_wd = '0;
    fsm_re = '0; fsm_we = '0; clear_accs = 0; fsm_done = 0;
    for (int k = 0; k < LANES; k++) begin laddr[k] = '0; lwd[k] = '0; end
  endtask

  task automatic host_wr(input int a, input logic [31:0] d);
    avl_cs = 1; avl_write = 1; avl_addr = AW'(a); avl_wd = d;
    tick();
    avl_cs = 0; avl_write = 0;
  endtask

  task automatic host_rd(input int a);
    avl_cs = 1; avl_read = 1; avl_addr = AW'(a);
    tick();
    avl_cs = 0; avl_read = 0;
  endtask

  initial begin
    int n;
    RESET_N = 1'b0;
    idle();
    model_reset();
    @(negedge CLK); @(negedge CLK);
    check_all();
    RESET_N = 1'b1;
    @(negedge CLK);

    // Basic host path
    host_wr(0, 32'h40800000);
    host_wr(1, 32'd2);
    host_wr(25, 32'hBF800000);
    host_rd(25);
    chk("rd25", avl_rdata, 32'hBF800000);
    chk("g_const", g_out, 32'h40800000);
    chk("pnum_2", {28'b0, pnum}, 32'd2);

    // NUM saturation, out-of-range address
    host_wr(1, 32'd15);
    chk("pnum_sat", {28'b0, pnum}, 32'd10);
    host_rd(1);
    chk("num_sat", avl_rdata, 32'd10);
    host_wr(200, 32'hDEADBEEF);
    host_rd(200);
    chk("rd200", avl_rdata, 32'd0);

    // START/DONE handshake and write lockout
    host_wr(2, 32'd1);
    chk("start_set", {31'b0, fsm_start}, 32'd1);
    host_rd(3);
    chk("done_clr", avl_rdata, 32'd0);
    host_wr(4, 32'd123);
    host_rd(4);
    chk("locked", avl_rdata, 32'd0);
    fsm_done = 1; tick(); fsm_done = 0;
    chk("start_clr", {31'b0, fsm_start}, 32'd0);
    host_rd(3);
    chk("done_set", avl_rdata, 32'd1);

    // Grouped engine reads
    host_wr(4, 32'h11); host_wr(5, 32'h22); host_wr(24, 32'h33);
    host_wr(34, 32'h55); host_wr(35, 32'h66);
    laddr[0] = 4; laddr[1] = 5; laddr[2] = 24; laddr[3] = 25; laddr[4] = 34; laddr[5] = 35;
    fsm_re = 2'b11; tick(); fsm_re = 2'b00;
    chk("lane0", rdata[0 +: 32], 32'h11);
    chk("lane3", rdata[96 +: 32], 32'hBF800000);
    chk("lane5", rdata[160 +: 32], 32'h66);
    for (int k = 0; k < LANES; k++) laddr[k] = '0;
    fsm_re = 2'b01; tick(); fsm_re = 2'b00;
    chk("lane1_new", rdata[32 +: 32], 32'h40800000);
    chk("lane4_hold", rdata[128 +: 32], 32'h55);

    // Acceleration clear sweep
    for (int i = 4 + 8*MP; i < DEPTH; i++) host_wr(i, 32'h3F800000);
    clear_accs = 1; tick(); clear_accs = 0;
    n = 0;
    for (int c = 0; c < 20 && clear_busy; c++) begin
      n++;
      if (c == 3) clear_accs = 1;
      tick();
      clear_accs = 0;
    end
    chk("busy_len", 32'(n), 32'd10);
    for (int i = 4 + 8*MP; i < DEPTH; i++) begin
      host_rd(i);
      chk("acc_zero", avl_rdata, 32'd0);
    end

    // Same-address write priority
    for (int k = 0; k < LANES; k++) begin laddr[k] = 8'd255; lwd[k] = 32'h0; end
    laddr[0] = 40; lwd[0] = 32'hAAAA0000;
    laddr[5] = 40; lwd[5] = 32'h5555FFFF;
    fsm_we = 2'b11;
    avl_cs = 1; avl_write = 1; avl_addr = 40; avl_wd = 32'h12345678;
    tick();
    idle();
    host_rd(40);
    chk("prio40", avl_rdata, 32'h5555FFFF);

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      avl_cs    = ($urandom_range(0, 3) != 0);
      avl_read  = $urandom_range(0, 1) == 1;
      avl_write = $urandom_range(0, 1) == 1;
      avl_addr  = ($urandom_range(0, 15) == 0) ? 8'd200 : AW'($urandom_range(0, DEPTH-1));
      avl_wd    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      fsm_re    = NG'($urandom_range(0, 3));
      fsm_we    = ($urandom_range(0, 2) == 0) ? NG'($urandom_range(0, 3)) : '0;
      for (int k = 0; k < LANES; k++) begin
        laddr[k] = AW'($urandom_range(0, 127));
        lwd[k]   = $urandom;
      end
      fsm_done   = ($urandom_range(0, 9) == 0);
      clear_accs = ($urandom_range(0, 14) == 0);
      tick();
    end
    idle();

    // Reset in the middle of a sweep
    clear_accs = 1; tick(); clear_accs = 0;
    tick(); tick(); tick();
    RESET_N = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", {31'b0, clear_busy}, 32'd0);
    check_all();
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    host_rd(0);
    chk("rst_w0", avl_rdata, 32'd0);
    host_rd(40);
    chk("rst_w40", avl_rdata, 32'd0);
    host_rd(25);
    chk("rst_w25", avl_rdata, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
